// File: rtl/dram_pkg.sv
// Shared constants and helpers for the refreshed DRAM array and its row cells.
package dram_pkg;

    localparam logic [0:0] StateIdle    = 1'b0;
    localparam logic [0:0] StateRefresh = 1'b1;

    localparam int unsigned DefaultDataWidth       = 8;
    localparam int unsigned DefaultRows            = 8;
    localparam int unsigned DefaultRefreshInterval = 4;
    localparam int unsigned DefaultRetentionCycles = 64;

    // Bits needed to hold any value in 0..maxValue.
    function automatic int unsigned counterWidth(input int unsigned maxValue);
        return (maxValue < 2) ? 1 : $clog2(maxValue + 1);
    endfunction

endpackage

// File: rtl/dram_row_cell.sv
// One DRAM row: data word plus a saturating age counter that zeroes the word when it
// reaches the retention limit.
module dram_row_cell
    import dram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DefaultDataWidth,
    parameter int unsigned RETENTION_CYCLES = DefaultRetentionCycles
) (
    input  logic                  ClockEdge,
    input  logic                  nReset,
    input  logic                  writeEn,
    input  logic                  restoreEn,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] rowData,
    output logic                  decayPulse
);

    localparam int unsigned AgeWidth = counterWidth(RETENTION_CYCLES);
    localparam logic [AgeWidth-1:0] AgeLimit = AgeWidth'(RETENTION_CYCLES);

    logic [AgeWidth-1:0]   ageQ, ageD;
    logic [DATA_WIDTH-1:0] dataQ, dataD;

    // Any access or refresh to this row wins over a decay landing on the same edge.
    always_comb begin
        ageD       = ageQ;
        dataD      = dataQ;
        decayPulse = 1'b0;
        if (writeEn) begin
            dataD = writeData;
            ageD  = '0;
        end else if (restoreEn) begin
            ageD = '0;
        end else if (ageQ < AgeLimit) begin
            ageD = ageQ + 1'b1;
            if (ageQ == AgeLimit - 1'b1) begin
                dataD      = '0;
                decayPulse = 1'b1;
            end
        end
    end

    always_ff @(posedge ClockEdge or negedge nReset) begin
        if (!nReset) begin
            ageQ  <= '0;
            dataQ <= '0;
        end else begin
            ageQ  <= ageD;
            dataQ <= dataD;
        end
    end

    assign rowData = dataQ;

endmodule

// File: rtl/dram_array_refresh.sv
// DRAM array with valid/ready access port, round-robin refresh scheduler, external
// refresh requests and sticky decay reporting.
module dram_array_refresh
    import dram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DefaultDataWidth,
    parameter int unsigned ROWS             = DefaultRows,
    parameter int unsigned REFRESH_INTERVAL = DefaultRefreshInterval,
    parameter int unsigned RETENTION_CYCLES = DefaultRetentionCycles,
    parameter int unsigned AW               = $clog2(ROWS)
) (
    input  logic                  ClockEdge,
    input  logic                  nReset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [AW-1:0]         ReqAddr,
    input  logic [DATA_WIDTH-1:0] inputData,
    output logic [DATA_WIDTH-1:0] outputData,
    output logic                  ReadValid,
    input  logic                  RefreshEdge,
    output logic                  RefreshBusy,
    output logic [AW-1:0]         RefreshRow,
    output logic                  DecayError
);

    localparam int unsigned TimerWidth = counterWidth(REFRESH_INTERVAL - 1);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(REFRESH_INTERVAL - 1);
    localparam logic [AW-1:0] RowLast = AW'(ROWS - 1);

    logic [0:0]            stateQ, stateD;
    logic [TimerWidth-1:0] timerQ, timerD;
    logic                  pendingQ, pendingD;
    logic [AW-1:0]         rowPtrQ, rowPtrD;
    logic [DATA_WIDTH-1:0] readDataQ, readDataD;
    logic                  readValidQ, readValidD;
    logic                  decayErrQ, decayErrD;

    logic                  pendingSet;
    logic                  accept;
    logic                  readAccept;
    logic [DATA_WIDTH-1:0] rowData [2**AW];
    logic [ROWS-1:0]       decayPulse;

    assign ReqReady    = (stateQ == StateIdle) && !pendingQ;
    assign RefreshBusy = (stateQ == StateRefresh);
    assign accept      = ReqValid && ReqReady;
    assign readAccept  = accept && !ReqWrite;
    assign pendingSet  = (timerQ == TimerLast) || RefreshEdge;

    // Unpopulated address slots (non power-of-two ROWS) read back as zero.
    for (genvar r = 0; r < 2**AW; r++) begin : gRow
        if (r < ROWS) begin : gCell
            logic hit;
            assign hit = (ReqAddr == AW'(r));
            dram_row_cell #(
                .DATA_WIDTH      (DATA_WIDTH),
                .RETENTION_CYCLES(RETENTION_CYCLES)
            ) uCell (
                .ClockEdge (ClockEdge),
                .nReset    (nReset),
                .writeEn   (accept && ReqWrite && hit),
                .restoreEn ((readAccept && hit) || (RefreshBusy && (rowPtrQ == AW'(r)))),
                .writeData (inputData),
                .rowData   (rowData[r]),
                .decayPulse(decayPulse[r])
            );
        end else begin : gEmpty
            assign rowData[r] = '0;
        end
    end

    // A set arriving on the cycle pending is consumed survives and yields another refresh.
    always_comb begin
        stateD   = stateQ;
        pendingD = pendingQ || pendingSet;
        rowPtrD  = rowPtrQ;
        case (stateQ)
            StateIdle: begin
                if (pendingQ) begin
                    stateD   = StateRefresh;
                    pendingD = pendingSet;
                end
            end
            StateRefresh: begin
                rowPtrD  = (rowPtrQ == RowLast) ? '0 : rowPtrQ + 1'b1;
                stateD   = (pendingQ || pendingSet) ? StateRefresh : StateIdle;
                pendingD = 1'b0;
            end
            default: stateD = StateIdle;
        endcase
    end

    always_comb begin
        timerD     = (timerQ == TimerLast) ? '0 : timerQ + 1'b1;
        readDataD  = readAccept ? rowData[ReqAddr] : readDataQ;
        readValidD = readAccept;
        decayErrD  = decayErrQ || (|decayPulse);
    end

    always_ff @(posedge ClockEdge or negedge nReset) begin
        if (!nReset) begin
            stateQ     <= StateIdle;
            timerQ     <= '0;
            pendingQ   <= 1'b0;
            rowPtrQ    <= '0;
            readDataQ  <= '0;
            readValidQ <= 1'b0;
            decayErrQ  <= 1'b0;
        end else begin
            stateQ     <= stateD;
            timerQ     <= timerD;
            pendingQ   <= pendingD;
            rowPtrQ    <= rowPtrD;
            readDataQ  <= readDataD;
            readValidQ <= readValidD;
            decayErrQ  <= decayErrD;
        end
    end

    assign RefreshRow = rowPtrQ;
    assign outputData = readDataQ;
    assign ReadValid  = readValidQ;
    assign DecayError = decayErrQ;

endmodule

// File: tb/tb_dram_array_refresh.sv
// Directed bench for dram_array_refresh: a default instance plus a short-retention one.
module tb_dram_array_refresh;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       ReqValid = 1'b0;
    logic       ReqWrite = 1'b0;
    logic [2:0] ReqAddr = '0;
    logic [7:0] inputData = '0;
    logic       RefreshEdge = 1'b0;

    logic       ReqReady, ReadValid, RefreshBusy, DecayError;
    logic [7:0] outputData;
    logic [2:0] RefreshRow;

    logic       d2ReqReady, d2ReadValid, d2RefreshBusy, d2DecayError;
    logic [7:0] d2OutputData;
    logic [2:0] d2RefreshRow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dram_array_refresh uDut (
        .ClockEdge  (clk),
        .nReset     (nReset),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqWrite   (ReqWrite),
        .ReqAddr    (ReqAddr),
        .inputData  (inputData),
        .outputData (outputData),
        .ReadValid  (ReadValid),
        .RefreshEdge(RefreshEdge),
        .RefreshBusy(RefreshBusy),
        .RefreshRow (RefreshRow),
        .DecayError (DecayError)
    );

    dram_array_refresh #(
        .RETENTION_CYCLES(16)
    ) uDutShort (
        .ClockEdge  (clk),
        .nReset     (nReset),
        .ReqValid   (ReqValid),
        .ReqReady   (d2ReqReady),
        .ReqWrite   (ReqWrite),
        .ReqAddr    (ReqAddr),
        .inputData  (inputData),
        .outputData (d2OutputData),
        .ReadValid  (d2ReadValid),
        .RefreshEdge(RefreshEdge),
        .RefreshBusy(d2RefreshBusy),
        .RefreshRow (d2RefreshRow),
        .DecayError (d2DecayError)
    );

    task automatic idleInputs();
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; inputData = '0; RefreshEdge = 1'b0;
    endtask

    // Returns at the falling edge of cycle 0 (timer 0, first cycle after release).
    task automatic applyReset();
        @(negedge clk);
        nReset = 1'b0;
        idleInputs();
        @(negedge clk);
        nReset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        applyReset();
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 3'd1; inputData = 8'h3C;
        step(1);
        ReqWrite = 1'b0;
        step(1);
        checks++; if (outputData !== 8'h3C || ReadValid !== 1'b1) begin errors++;
            $display("FAIL rst_preread: data=%h valid=%b want 3c/1", outputData, ReadValid); end
        // Another read is accepted on the coming edge; reset lands first and must drop it.
        #1 nReset = 1'b0; ReqValid = 1'b0;
        #1;
        checks++; if (outputData !== 8'h00) begin errors++;
            $display("FAIL rst_data: got %h want 00", outputData); end
        checks++; if (ReadValid !== 1'b0) begin errors++;
            $display("FAIL rst_valid: got %b want 0", ReadValid); end
        @(negedge clk);
        nReset = 1'b1;
        checks++; if (ReqReady !== 1'b1) begin errors++;
            $display("FAIL rst_ready: got %b want 1", ReqReady); end
        checks++; if (RefreshRow !== 3'd0) begin errors++;
            $display("FAIL rst_row: got %0d want 0", RefreshRow); end
        step(1);
        checks++; if (ReadValid !== 1'b0) begin errors++;
            $display("FAIL rst_dropread: got %b want 0", ReadValid); end
        step(4);
        checks++; if (RefreshBusy !== 1'b1) begin errors++;
            $display("FAIL rst_prebusy: got %b want 1", RefreshBusy); end
        #1 nReset = 1'b0;
        #1;
        checks++; if (RefreshBusy !== 1'b0) begin errors++;
            $display("FAIL rst_busy: got %b want 0", RefreshBusy); end
        @(negedge clk);
        nReset = 1'b1;
        step(16);
        checks++; if (d2DecayError !== 1'b1) begin errors++;
            $display("FAIL rst_predecay: got %b want 1", d2DecayError); end
        #1 nReset = 1'b0;
        #1;
        checks++; if (d2DecayError !== 1'b0) begin errors++;
            $display("FAIL rst_decay: got %b want 0", d2DecayError); end
    endtask

    task automatic test_write_read();
        applyReset();
        checks++; if (ReqReady !== 1'b1) begin errors++;
            $display("FAIL wr_ready: got %b want 1", ReqReady); end
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 3'd3; inputData = 8'hA5;
        step(1);
        ReqWrite = 1'b0; ReqAddr = 3'd4; inputData = 8'h00;
        step(1);
        checks++; if (ReadValid !== 1'b1 || outputData !== 8'h00) begin errors++;
            $display("FAIL rd_addr4: valid=%b data=%h want 1/00", ReadValid, outputData); end
        ReqAddr = 3'd3;
        step(1);
        checks++; if (ReadValid !== 1'b1 || outputData !== 8'hA5) begin errors++;
            $display("FAIL rd_addr3: valid=%b data=%h want 1/a5", ReadValid, outputData); end
        ReqValid = 1'b0;
        step(1);
        checks++; if (ReadValid !== 1'b0 || outputData !== 8'hA5) begin errors++;
            $display("FAIL rd_hold: valid=%b data=%h want 0/a5", ReadValid, outputData); end
        checks++; if (ReqReady !== 1'b0) begin errors++;
            $display("FAIL rd_pendready: got %b want 0", ReqReady); end
    endtask

    task automatic test_scheduled_refresh();
        applyReset();
        for (int c = 0; c < 40; c++) begin
            logic expBusy, expReady;
            expBusy  = (c >= 5) && ((c - 5) % 4 == 0);
            expReady = !((c >= 4) && ((c - 4) % 4 < 2));
            checks++; if (RefreshBusy !== expBusy) begin errors++;
                $display("FAIL sched_busy c=%0d: got %b want %b", c, RefreshBusy, expBusy); end
            checks++; if (ReqReady !== expReady) begin errors++;
                $display("FAIL sched_ready c=%0d: got %b want %b", c, ReqReady, expReady); end
            if (c == 6 || c == 33 || c == 34) begin
                logic [2:0] expRow;
                expRow = (c == 6) ? 3'd1 : (c == 33) ? 3'd7 : 3'd0;
                checks++; if (RefreshRow !== expRow) begin errors++;
                    $display("FAIL sched_row c=%0d: got %0d want %0d", c, RefreshRow, expRow); end
            end
            step(1);
        end
        step(460);
        checks++; if (DecayError !== 1'b0) begin errors++;
            $display("FAIL sched_nodecay: got %b want 0", DecayError); end
        checks++; if (RefreshRow !== 3'd4) begin errors++;
            $display("FAIL sched_row500: got %0d want 4", RefreshRow); end
    endtask

    task automatic test_collision();
        applyReset();
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 3'd3; inputData = 8'hA5;
        step(1);
        idleInputs();
        step(3);
        checks++; if (ReqReady !== 1'b0) begin errors++;
            $display("FAIL col_pend: ready=%b want 0", ReqReady); end
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 3'd3;
        step(1);
        checks++; if (RefreshBusy !== 1'b1 || ReqReady !== 1'b0 || ReadValid !== 1'b0) begin
            errors++;
            $display("FAIL col_refresh: busy=%b ready=%b valid=%b want 1/0/0",
                     RefreshBusy, ReqReady, ReadValid); end
        step(1);
        checks++; if (ReqReady !== 1'b1 || ReadValid !== 1'b0) begin errors++;
            $display("FAIL col_accept: ready=%b valid=%b want 1/0", ReqReady, ReadValid); end
        step(1);
        checks++; if (ReadValid !== 1'b1 || outputData !== 8'hA5) begin errors++;
            $display("FAIL col_data: valid=%b data=%h want 1/a5", ReadValid, outputData); end
        ReqValid = 1'b0;
        step(1);
        checks++; if (ReadValid !== 1'b0) begin errors++;
            $display("FAIL col_pulse: valid=%b want 0", ReadValid); end
    endtask

    task automatic test_external_refresh();
        applyReset();
        step(3);
        RefreshEdge = 1'b1;
        step(1);
        RefreshEdge = 1'b0;
        checks++; if (ReqReady !== 1'b0 || RefreshBusy !== 1'b0) begin errors++;
            $display("FAIL ext_pend: ready=%b busy=%b want 0/0", ReqReady, RefreshBusy); end
        step(1);
        checks++; if (RefreshBusy !== 1'b1) begin errors++;
            $display("FAIL ext_single_busy: got %b want 1", RefreshBusy); end
        step(1);
        checks++; if (RefreshBusy !== 1'b0 || RefreshRow !== 3'd1) begin errors++;
            $display("FAIL ext_single_end: busy=%b row=%0d want 0/1", RefreshBusy, RefreshRow); end
        step(3);
        checks++; if (RefreshBusy !== 1'b1 || RefreshRow !== 3'd1) begin errors++;
            $display("FAIL ext_b2b_first: busy=%b row=%0d want 1/1", RefreshBusy, RefreshRow); end
        RefreshEdge = 1'b1;
        step(1);
        RefreshEdge = 1'b0;
        checks++; if (RefreshBusy !== 1'b1 || RefreshRow !== 3'd2) begin errors++;
            $display("FAIL ext_b2b_second: busy=%b row=%0d want 1/2", RefreshBusy, RefreshRow); end
        step(1);
        checks++; if (RefreshBusy !== 1'b0 || RefreshRow !== 3'd3) begin errors++;
            $display("FAIL ext_b2b_end: busy=%b row=%0d want 0/3", RefreshBusy, RefreshRow); end
        step(1);
        checks++; if (ReqReady !== 1'b0 || RefreshBusy !== 1'b0) begin errors++;
            $display("FAIL ext_resched: ready=%b busy=%b want 0/0", ReqReady, RefreshBusy); end
        step(1);
        checks++; if (RefreshBusy !== 1'b1) begin errors++;
            $display("FAIL ext_resched_busy: got %b want 1", RefreshBusy); end
    endtask

    task automatic test_decay();
        applyReset();
        checks++; if (d2ReqReady !== 1'b1) begin errors++;
            $display("FAIL dec_ready: got %b want 1", d2ReqReady); end
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 3'd7; inputData = 8'h5A;
        step(1);
        idleInputs();
        step(14);
        checks++; if (d2DecayError !== 1'b0) begin errors++;
            $display("FAIL dec_early: got %b want 0", d2DecayError); end
        step(1);
        checks++; if (d2DecayError !== 1'b1 || d2RefreshRow !== 3'd3) begin errors++;
            $display("FAIL dec_flag: err=%b row=%0d want 1/3", d2DecayError, d2RefreshRow); end
        step(1);
        checks++; if (d2RefreshBusy !== 1'b1) begin errors++;
            $display("FAIL dec_busy: got %b want 1", d2RefreshBusy); end
        step(1);
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 3'd7;
        step(1);
        checks++; if (d2ReadValid !== 1'b1 || d2OutputData !== 8'h00) begin errors++;
            $display("FAIL dec_read: valid=%b data=%h want 1/00", d2ReadValid, d2OutputData); end
        ReqValid = 1'b0;
        step(5);
        checks++; if (d2DecayError !== 1'b1) begin errors++;
            $display("FAIL dec_sticky: got %b want 1", d2DecayError); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_scheduled_refresh();
        test_collision();
        test_external_refresh();
        test_decay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
